mac_array_db: RTL and testbench

//  Parametrised ROWxCOL weight-stationary systolic MAC array with double-buffered (ping-pong) weights.

---
 rtl/mac_array_db.sv | 175 +++++++++++++++++
 tb/tb_mac_array_db.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_db.sv
`default_nettype none
// ============================================================================
// mac_array_db : ROWxCOL weight-stationary systolic MAC array, ping-pong weights
// Rev 1.0
// ============================================================================
module mac_array_db #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int X_BW    = 4,
  parameter int W_BW    = 4,
  parameter int PSUM_BW = 16,
  parameter int SAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   prec,
  input  logic [2:0]             inst,
  input  logic [ROW*X_BW-1:0]    in_x,
  input  logic [ROW*2*W_BW-1:0]  in_w,
  input  logic [COL*PSUM_BW-1:0] in_psum,
  output logic [COL*PSUM_BW-1:0] out_s,
  output logic [COL-1:0]         valid,
  output logic                   busy,
  output logic                   err
);
  localparam int HX = X_BW / 2;
  localparam int LW = 2 * W_BW;
  localparam int PW = PSUM_BW + 1;
  localparam logic signed [PW-1:0] PMAX = {2'b00, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {2'b11, {(PSUM_BW-1){1'b0}}};

  function automatic logic signed [PW-1:0] mul(input logic [X_BW-1:0] x,
                                               input logic [W_BW-1:0] w);
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] ws;
    xs = $signed(PW'(x));
    ws = PW'($signed(w));
    return xs * ws;
  endfunction

  // vtok_q[r] feeds row r+1 column 0; htok/hx/hw_q[r][c] feed PE(r,c+1)
  logic [2:0]         vtok_q [ROW-1];
  logic [2:0]         vtok_d [ROW-1];
  logic [2:0]         htok_q [ROW][COL-1];
  logic [2:0]         htok_d [ROW][COL-1];
  logic [X_BW-1:0]    hx_q   [ROW][COL-1];
  logic [X_BW-1:0]    hx_d   [ROW][COL-1];
  logic [LW-1:0]      hw_q   [ROW][COL-1];
  logic [LW-1:0]      hw_d   [ROW][COL-1];
  logic [LW-1:0]      wb_q   [ROW][COL][2];
  logic [LW-1:0]      wb_d   [ROW][COL][2];
  logic               sel_q  [ROW][COL];
  logic               sel_d  [ROW][COL];
  logic               full_q [ROW][COL];
  logic               full_d [ROW][COL];
  logic [PSUM_BW-1:0] psum_q [ROW][COL];
  logic [PSUM_BW-1:0] psum_d [ROW][COL];
  logic [COL-1:0]     valid_q, valid_d;
  logic               err_q, err_d;

  logic [2:0]         tok_i  [ROW][COL];
  logic [2:0]         fwd    [ROW][COL];
  logic [X_BW-1:0]    x_i    [ROW][COL];
  logic [LW-1:0]      w_i    [ROW][COL];
  logic [PSUM_BW-1:0] p_i    [ROW][COL];
  logic [2:0]         inst_m;

  always_comb begin
    logic [LW-1:0]        act;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] acc;
    act    = '0;
    prod   = '0;
    acc    = '0;
    wb_d   = wb_q;
    sel_d  = sel_q;
    full_d = full_q;
    err_d  = err_q;
    busy   = 1'b0;

    // A simultaneous LOAD+SWAP keeps the SWAP and discards the LOAD
    inst_m = inst;
    if (inst[1] && inst[2]) begin
      inst_m[1] = 1'b0;
      err_d     = 1'b1;
    end

    tok_i[0][0] = inst_m;
    for (int r = 1; r < ROW; r++) tok_i[r][0] = vtok_q[r-1];
    for (int r = 0; r < ROW; r++) begin
      x_i[r][0] = in_x[X_BW*r +: X_BW];
      w_i[r][0] = in_w[LW*r +: LW];
      for (int c = 1; c < COL; c++) begin
        tok_i[r][c] = htok_q[r][c-1];
        x_i[r][c]   = hx_q[r][c-1];
        w_i[r][c]   = hw_q[r][c-1];
      end
    end
    for (int c = 0; c < COL; c++) p_i[0][c] = in_psum[PSUM_BW*c +: PSUM_BW];
    for (int r = 1; r < ROW; r++)
      for (int c = 0; c < COL; c++) p_i[r][c] = psum_q[r-1][c];

    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        act = wb_q[r][c][sel_q[r][c]];
        if (prec)
          prod = mul(x_i[r][c], act[W_BW-1:0]);
        else
          prod = mul(X_BW'(x_i[r][c][HX-1:0]), act[W_BW-1:0])
               + mul(X_BW'(x_i[r][c][X_BW-1:HX]), act[LW-1:W_BW]);
        acc = PW'($signed(p_i[r][c])) + prod;
        if (SAT != 0 && acc > PMAX) acc = PMAX;
        else if (SAT != 0 && acc < PMIN) acc = PMIN;
        psum_d[r][c] = tok_i[r][c][0] ? acc[PSUM_BW-1:0] : p_i[r][c];

        fwd[r][c] = tok_i[r][c];
        if (tok_i[r][c][1] && !full_q[r][c]) begin
          wb_d[r][c][~sel_q[r][c]] = w_i[r][c];
          full_d[r][c]             = 1'b1;
          fwd[r][c][1]             = 1'b0;
        end
        if (tok_i[r][c][2]) begin
          sel_d[r][c]  = ~sel_q[r][c];
          full_d[r][c] = 1'b0;
        end
      end
    end

    for (int r = 0; r < ROW - 1; r++) vtok_d[r] = tok_i[r][0];
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL - 1; c++) begin
        htok_d[r][c] = fwd[r][c];
        hx_d[r][c]   = x_i[r][c];
        hw_d[r][c]   = w_i[r][c];
      end
      if (fwd[r][COL-1][1]) err_d = 1'b1;
    end
    for (int c = 0; c < COL; c++) valid_d[c] = tok_i[ROW-1][c][0];

    for (int r = 0; r < ROW - 1; r++) busy = busy | (|vtok_q[r]);
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL - 1; c++) busy = busy | (|htok_q[r][c]);
    for (int c = 0; c < COL; c++) out_s[PSUM_BW*c +: PSUM_BW] = psum_q[ROW-1][c];
  end

  assign valid = valid_q;
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vtok_q  <= '{default: '0};
      htok_q  <= '{default: '0};
      hx_q    <= '{default: '0};
      hw_q    <= '{default: '0};
      wb_q    <= '{default: '0};
      sel_q   <= '{default: '0};
      full_q  <= '{default: '0};
      psum_q  <= '{default: '0};
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vtok_q  <= vtok_d;
      htok_q  <= htok_d;
      hx_q    <= hx_d;
      hw_q    <= hw_d;
      wb_q    <= wb_d;
      sel_q   <= sel_d;
      full_q  <= full_d;
      psum_q  <= psum_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mac_array_db.sv
`default_nettype none
// ============================================================================
// tb_mac_array_db : random + directed check of mac_array_db (SAT=1 and SAT=0)
// Rev 1.0
// ============================================================================
module tb_mac_array_db;
  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int D    = ROW + COL - 2;
  localparam int NCYC = 4096;
  localparam logic [2:0] EXEC = 3'b001, LOAD = 3'b010, SWAP = 3'b100;

  logic             clk = 1'b0;
  logic             reset, prec;
  logic [2:0]       inst;
  logic [ROW*4-1:0] in_x;
  logic [ROW*8-1:0] in_w;
  logic [COL*16-1:0] in_psum, out_a, out_b;
  logic [COL-1:0]   val_a, val_b;
  logic             busy_a, busy_b, err_a, err_b;

  always #5 clk = ~clk;

  mac_array_db #(.SAT(1)) u_sat (.clk(clk), .reset(reset), .prec(prec), .inst(inst),
    .in_x(in_x), .in_w(in_w), .in_psum(in_psum), .out_s(out_a), .valid(val_a),
    .busy(busy_a), .err(err_a));
  mac_array_db #(.SAT(0)) u_wrap (.clk(clk), .reset(reset), .prec(prec), .inst(inst),
    .in_x(in_x), .in_w(in_w), .in_psum(in_psum), .out_s(out_b), .valid(val_b),
    .busy(busy_b), .err(err_b));

  int checks = 0, failures = 0, n = 0;
  int cur_x[ROW], cur_w0[ROW], cur_w1[ROW], cur_ps[COL];
  bit [3:0]       x_tab [NCYC][ROW];
  bit [7:0]       w_tab [NCYC][ROW];
  bit [COL-1:0]   exp_v [NCYC];
  int             exp_sat [NCYC][COL];
  int             exp_wrap[NCYC][COL];
  // Abstract model: per-PE bank contents, active bank and shadow-full flag
  int mw0[ROW][COL][2], mw1[ROW][COL][2], msel[ROW][COL];
  bit mfull[ROW][COL];
  int err_at, last_nz, last_es;
  bit rst_prev;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, n, got, exp);
    end
  endtask

  function automatic int sat16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap16(int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int pe_prod(int r, int c);
    int b;
    int x;
    b = msel[r][c];
    x = cur_x[r];
    if (prec) return x * mw0[r][c][b];
    return (x % 4) * mw0[r][c][b] + (x / 4) * mw1[r][c][b];
  endfunction

  task automatic model_reset();
    for (int t = n + 1; t <= n + ROW + COL + 1; t++) exp_v[t] = '0;
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) begin
        mw0[r][c] = '{0, 0}; mw1[r][c] = '{0, 0};
        msel[r][c] = 0; mfull[r][c] = 1'b0;
      end
    err_at = 1 << 30; last_nz = -1000; last_es = -1000;
  endtask

  task automatic model_issue(input logic [2:0] i);
    bit e, l, s, found;
    int acc_s, acc_w, p;
    e = i[0]; l = i[1]; s = i[2];
    if (l && s) begin
      l = 1'b0;
      if (n + 1 < err_at) err_at = n + 1;
    end
    for (int r = 0; r < ROW; r++) begin
      x_tab[n+r][r] = cur_x[r][3:0];
      w_tab[n+r][r] = {cur_w1[r][3:0], cur_w0[r][3:0]};
    end
    if (e)
      for (int c = 0; c < COL; c++) begin
        acc_s = cur_ps[c]; acc_w = cur_ps[c];
        for (int r = 0; r < ROW; r++) begin
          p = pe_prod(r, c);
          acc_s = sat16(acc_s + p);
          acc_w = wrap16(acc_w + p);
        end
        exp_v[n+ROW+c][c] = 1'b1;
        exp_sat[n+ROW+c][c] = acc_s;
        exp_wrap[n+ROW+c][c] = acc_w;
      end
    if (l)
      for (int r = 0; r < ROW; r++) begin
        found = 1'b0;
        for (int c = 0; c < COL; c++)
          if (!found && !mfull[r][c]) begin
            mw0[r][c][1-msel[r][c]] = cur_w0[r];
            mw1[r][c][1-msel[r][c]] = cur_w1[r];
            mfull[r][c] = 1'b1;
            found = 1'b1;
          end
        if (!found && n + r + COL < err_at) err_at = n + r + COL;
      end
    if (s)
      for (int r = 0; r < ROW; r++)
        for (int c = 0; c < COL; c++) begin
          msel[r][c] = 1 - msel[r][c];
          mfull[r][c] = 1'b0;
        end
    last_nz = n;
    if (e || s) last_es = n;
  endtask

  task automatic check_cycle();
    for (int c = 0; c < COL; c++) begin
      if (exp_v[n][c]) begin
        check("out_sat", $signed(out_a[16*c +: 16]), exp_sat[n][c]);
        check("out_wrap", $signed(out_b[16*c +: 16]), exp_wrap[n][c]);
      end
      if (rst_prev) begin
        check("rst_out_sat", $signed(out_a[16*c +: 16]), 0);
        check("rst_out_wrap", $signed(out_b[16*c +: 16]), 0);
      end
    end
    check("valid_sat", val_a, exp_v[n]);
    check("valid_wrap", val_b, exp_v[n]);
    check("err_sat", err_a, n >= err_at);
    check("err_wrap", err_b, n >= err_at);
    if (last_es < n && n <= last_es + D) begin
      check("busy_hi", busy_a, 1);
      check("busy_hi_wrap", busy_b, 1);
    end else if (last_nz < n - D) begin
      check("busy_lo", busy_a, 0);
      check("busy_lo_wrap", busy_b, 0);
    end
  endtask

  task automatic tick(input logic [2:0] i, input logic r_v);
    @(posedge clk);
    #1;
    n++;
    if (n + ROW + COL + 2 >= NCYC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", n, NCYC);
      $fatal(1, "cycle budget exceeded");
    end
    check_cycle();
    rst_prev = r_v;
    reset = r_v;
    if (r_v) model_reset();
    else if (i != 3'b000) model_issue(i);
    inst = r_v ? 3'b000 : i;
    for (int r = 0; r < ROW; r++) begin
      in_x[4*r +: 4] = x_tab[n][r];
      in_w[8*r +: 8] = w_tab[n][r];
    end
    for (int c = 0; c < COL; c++) in_psum[16*c +: 16] = cur_ps[c][15:0];
  endtask

  task automatic set_x(input int v);
    for (int r = 0; r < ROW; r++) cur_x[r] = v;
  endtask
  task automatic rand_x();
    for (int r = 0; r < ROW; r++) cur_x[r] = int'($urandom_range(0, 15));
  endtask
  task automatic set_w(input int w0, input int w1);
    for (int r = 0; r < ROW; r++) begin cur_w0[r] = w0; cur_w1[r] = w1; end
  endtask
  task automatic set_ps(input int v);
    for (int c = 0; c < COL; c++) cur_ps[c] = v;
  endtask
  task automatic drain();
    repeat (D + 3) tick(3'b000, 1'b0);
  endtask
  task automatic load_row(input int w0, input int w1);
    set_w(w0, w1);
    for (int c = 0; c < COL; c++) tick(LOAD, 1'b0);
  endtask

  initial begin
    logic [2:0] ri;
    reset = 1'b1; prec = 1'b1; inst = '0; in_x = '0; in_w = '0; in_psum = '0;
    set_x(0); set_w(0, 0); set_ps(0);
    model_reset();
    rst_prev = 1'b1;
    tick(3'b000, 1'b1); tick(3'b000, 1'b1); tick(3'b000, 1'b0);

    // Per-column weights c-3, single 4b activation = 1
    set_w(0, 0);
    for (int c = 0; c < COL; c++) begin set_w(c - 3, 0); tick(LOAD, 1'b0); end
    tick(SWAP, 1'b0);
    set_x(1); tick(EXEC, 1'b0);
    drain();

    // Ping-pong: execute on bank A while loading bank B, then swap mid-stream
    load_row(1, 0); tick(SWAP, 1'b0);
    set_w(2, 0);
    for (int k = 0; k < COL; k++) begin rand_x(); tick(EXEC | LOAD, 1'b0); end
    rand_x(); tick(EXEC | SWAP, 1'b0);
    for (int k = 0; k < 6; k++) begin rand_x(); tick(EXEC, 1'b0); end
    drain();

    // Dual 2b lanes: x1=3, x0=2, w1=-1, w0=2
    prec = 1'b0;
    load_row(2, -1); tick(SWAP, 1'b0);
    set_x(14); tick(EXEC, 1'b0);
    drain();

    // Saturation at both rails
    prec = 1'b1; set_ps(32760);
    load_row(7, 0); tick(SWAP, 1'b0);
    set_x(15); tick(EXEC, 1'b0);
    drain();
    set_ps(-32760);
    load_row(-8, 0); tick(SWAP, 1'b0);
    set_x(15); tick(EXEC, 1'b0);
    drain();
    set_ps(0);

    // Errors: LOAD+SWAP, then a 9th LOAD into a full row
    tick(3'b000, 1'b1); tick(3'b000, 1'b1);
    load_row(3, 0); tick(SWAP, 1'b0);
    load_row(5, 0);
    set_w(-2, 0); tick(LOAD | SWAP, 1'b0);
    set_x(2); tick(EXEC, 1'b0);
    drain();
    tick(3'b000, 1'b1); tick(3'b000, 1'b1);
    for (int c = 0; c < COL; c++) begin set_w(c - 4, 1); tick(LOAD, 1'b0); end
    set_w(7, 7); tick(LOAD, 1'b0);
    tick(SWAP, 1'b0);
    set_x(3); tick(EXEC, 1'b0);
    drain();

    // Reset in the middle of an EXEC stream
    for (int c = 0; c < COL; c++) cur_ps[c] = c * 100 - 300;
    for (int k = 0; k < 10; k++) begin rand_x(); tick(EXEC, 1'b0); end
    tick(3'b000, 1'b1); tick(3'b000, 1'b1);
    rand_x(); tick(EXEC, 1'b0);
    drain();

    // Randomized bursts
    for (int b = 0; b < 16; b++) begin
      if (b == 8) begin tick(3'b000, 1'b1); tick(3'b000, 1'b1); end
      prec = 1'($urandom_range(0, 1));
      for (int c = 0; c < COL; c++) cur_ps[c] = int'($urandom_range(0, 65535)) - 32768;
      for (int k = 0; k < 40; k++) begin
        ri = 3'($urandom_range(0, 7));
        if (ri == 3'b110 && $urandom_range(0, 3) != 0) ri = 3'b011;
        rand_x();
        for (int r = 0; r < ROW; r++) begin
          cur_w0[r] = int'($urandom_range(0, 15)) - 8;
          cur_w1[r] = int'($urandom_range(0, 15)) - 8;
        end
        tick(ri, 1'b0);
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
